// File: rtl/conversor_bcd_if.sv
// Handshake/data bundle for conversor_bcd.
//   valor     : value to convert (driven by master)
//   iniciar   : start request (driven by master)
//   segmentos : packed BCD result, units in [3:0]
//   neg       : sign of the last converted value
//   estouro   : overflow flag (result does not fit in DIGITOS digits)
//   ocupado   : conversion in progress
//   pronto    : one-cycle pulse when new results are available
interface conversor_bcd_if;
  logic [31:0] valor;
  logic        iniciar;
  logic [31:0] segmentos;
  logic        neg;
  logic        estouro;
  logic        ocupado;
  logic        pronto;

  modport master (output valor, iniciar,
                  input  segmentos, neg, estouro, ocupado, pronto);
  modport slave  (input  valor, iniciar,
                  output segmentos, neg, estouro, ocupado, pronto);
endinterface

// File: rtl/conversor_bcd.sv
// Binary to BCD converter using sequential double dabble (shift-add-3).
// A start sampled while idle captures the magnitude/sign; 32 edges later
// the result is registered and pronto pulses for one cycle.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : conversor_bcd_if.slave (valor, iniciar, segmentos, neg,
//           estouro, ocupado, pronto)
// Parameter DIGITOS (1..8): digits presented on segmentos; higher nibbles 0.
// Optional macro CONVERSOR_SINAL_EN: treat valor as two's complement and
// convert its magnitude; otherwise valor is unsigned and neg is tied to 0.
module conversor_bcd #(
  parameter int DIGITOS = 6
) (
  input logic            clock,
  input logic            reset,
  conversor_bcd_if.slave bus
);

  typedef enum logic {OCIOSO, CONVERTE} estado_t;

  estado_t     estado, estado_prox;
  logic [5:0]  cont;
  logic [31:0] mag;
  logic [39:0] bcd;          // 10 digits: enough for any 32-bit magnitude
  logic [39:0] bcd_adj;
  logic [71:0] desloc;
  logic [39:0] bcd_prox;
  logic [31:0] mag_prox;
  logic        fim;
  logic        ovf;
  logic [31:0] seg_prox;
  logic [31:0] mag_in;
  logic [31:0] seg_r;
  logic        est_r, ocup_r, pronto_r;

`ifdef CONVERSOR_SINAL_EN
  logic sinal, sinal_in, neg_r;
  assign sinal_in = bus.valor[31];
  // -32'h80000000 wraps to itself, which read as unsigned is 2^31.
  assign mag_in   = sinal_in ? -bus.valor : bus.valor;
  assign bus.neg  = neg_r;
`else
  assign mag_in   = bus.valor;
  assign bus.neg  = 1'b0;
`endif

  assign fim = (estado == CONVERTE) && (cont == 6'd31);

  // One double-dabble step: correct digits >= 5, then shift the whole
  // {bcd, mag} pair left so the magnitude MSB enters the units digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    desloc   = {bcd_adj, mag} << 1;
    bcd_prox = desloc[71:32];
    mag_prox = desloc[31:0];
  end

  // Result formatting from the final step's value.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < 10; i++)
      if (i >= DIGITOS && bcd_prox[4*i +: 4] != 4'd0) ovf = 1'b1;
    seg_prox = '0;
    for (int i = 0; i < 8; i++)
      if (i < DIGITOS) seg_prox[4*i +: 4] = ovf ? 4'hF : bcd_prox[4*i +: 4];
  end

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (bus.iniciar) estado_prox = CONVERTE;
      CONVERTE: if (fim)         estado_prox = OCIOSO;
      default:                   estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cont     <= '0;
      mag      <= '0;
      bcd      <= '0;
      seg_r    <= '0;
      est_r    <= 1'b0;
      ocup_r   <= 1'b0;
      pronto_r <= 1'b0;
`ifdef CONVERSOR_SINAL_EN
      sinal    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      pronto_r <= 1'b0;
      if (estado == OCIOSO) begin
        if (bus.iniciar) begin
          mag    <= mag_in;
          bcd    <= '0;
          cont   <= '0;
          ocup_r <= 1'b1;
`ifdef CONVERSOR_SINAL_EN
          sinal  <= sinal_in;
`endif
        end
      end else begin
        bcd  <= bcd_prox;
        mag  <= mag_prox;
        cont <= cont + 6'd1;
        if (fim) begin
          cont     <= '0;
          seg_r    <= seg_prox;
          est_r    <= ovf;
          pronto_r <= 1'b1;
          ocup_r   <= 1'b0;
`ifdef CONVERSOR_SINAL_EN
          // Only a zero magnitude can yield an all-zero BCD value.
          neg_r    <= sinal && (bcd_prox != '0);
`endif
        end
      end
    end
  end

  assign bus.segmentos = seg_r;
  assign bus.estouro   = est_r;
  assign bus.ocupado   = ocup_r;
  assign bus.pronto    = pronto_r;

endmodule

// File: tb/tb_conversor_bcd.sv
module tb_conversor_bcd;
  localparam int D = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  conversor_bcd_if bus ();
  conversor_bcd #(.DIGITOS(D)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: decimal digits by division, sign/overflow by plain arithmetic.
  function automatic void modelo(input logic [31:0] v, output logic [31:0] seg,
                                 output logic ng, output logic est);
    longint unsigned m, lim, p;
    bit s;
`ifdef CONVERSOR_SINAL_EN
    s = v[31];
`else
    s = 1'b0;
`endif
    m = s ? (64'd4294967296 - longint'(v)) : longint'(v);
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    est = (m >= lim);
    seg = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      seg[4*i +: 4] = est ? 4'hF : 4'((m / p) % 10);
      p = p * 10;
    end
    ng = s && (m != 0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full conversion; nk (1..32) injects a spurious start with value nv
  // before edge nk. valor is scrambled every cycle after capture.
  task automatic run(input logic [31:0] v, input int nk, input logic [31:0] nv,
                     input string tag);
    logic [31:0] es;
    logic en, ee;
    bit early;
    modelo(v, es, en, ee);
    bus.valor = v;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    chk({tag, ".ocupado_e0"}, 64'(bus.ocupado), 64'd1);
    chk({tag, ".pronto_e0"}, 64'(bus.pronto), 64'd0);
    early = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == nk) begin
        bus.iniciar = 1'b1;
        bus.valor = nv;
      end else begin
        bus.valor = $urandom;
      end
      step();
      bus.iniciar = 1'b0;
      if (k < 32 && (bus.pronto !== 1'b0 || bus.ocupado !== 1'b1)) early = 1'b1;
    end
    chk({tag, ".timing"}, 64'(early), 64'd0);
    chk({tag, ".pronto"}, 64'(bus.pronto), 64'd1);
    chk({tag, ".ocupado"}, 64'(bus.ocupado), 64'd0);
    chk({tag, ".segmentos"}, 64'(bus.segmentos), 64'(es));
    chk({tag, ".neg"}, 64'(bus.neg), 64'(en));
    chk({tag, ".estouro"}, 64'(bus.estouro), 64'(ee));
  endtask

  initial begin
    logic [31:0] hold;
    bit stray;
    logic [31:0] rv;

    // Reset with a simultaneous start: reset wins.
    reset = 1'b1;
    bus.iniciar = 1'b1;
    bus.valor = 32'd5;
    step();
    step();
    chk("rst.segmentos", 64'(bus.segmentos), 64'd0);
    chk("rst.neg", 64'(bus.neg), 64'd0);
    chk("rst.estouro", 64'(bus.estouro), 64'd0);
    chk("rst.ocupado", 64'(bus.ocupado), 64'd0);
    chk("rst.pronto", 64'(bus.pronto), 64'd0);
    reset = 1'b0;
    bus.iniciar = 1'b0;
    step();

    run(32'd1234, 0, 32'd0, "v1234");
    step();
    chk("v1234.pronto_drop", 64'(bus.pronto), 64'd0);
    hold = bus.segmentos;
    bus.valor = 32'd99;
    step(); step(); step();
    chk("v1234.hold", 64'(bus.segmentos), 64'(hold));
    chk("v1234.hold_const", 64'(bus.segmentos), 64'h1234);

    run(32'hFFFF_FFFB, 0, 32'd0, "vneg5");
    run(32'd999999, 0, 32'd0, "v999999");
    run(32'd1000000, 0, 32'd0, "v1000000");
    run(32'd0, 0, 32'd0, "vzero");
    run(32'h8000_0000, 0, 32'd0, "vmin");

    // Start during conversion is ignored; back-to-back start at E33.
    run(32'd42, 5, 32'd77, "v42");
    run(32'd77, 0, 32'd0, "v77");

    // Reset at E10 aborts the conversion without a pronto pulse.
    bus.valor = 32'd55;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    stray = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (bus.pronto !== 1'b0) stray = 1'b1;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.segmentos", 64'(bus.segmentos), 64'd0);
    chk("abort.ocupado", 64'(bus.ocupado), 64'd0);
    chk("abort.pronto", 64'(bus.pronto), 64'd0);
    chk("abort.estouro", 64'(bus.estouro), 64'd0);
    chk("abort.neg", 64'(bus.neg), 64'd0);
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) stray = 1'b1;
    end
    chk("abort.no_pronto", 64'(stray), 64'd0);
    run(32'd8, 0, 32'd0, "v8");

    // Random values, alternately in and beyond the digit range.
    for (int n = 0; n < 16; n++) begin
      rv = (n % 2 == 0) ? 32'($urandom_range(0, 999999)) : $urandom;
      run(rv, int'($urandom_range(1, 31)), $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 Parameter DIGITOS, default 6, sets the number of BCD digits presented on segmentos; legal range 1..8.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 valor  input  32  value to convert; two's complement when CONVERSOR_SINAL_EN is defined, unsigned otherwise.
REQ-005 iniciar  input  1  start request, sampled only while idle.
REQ-006 segmentos  output  32  registered BCD result, digit i at bits [4i+3:4i], units in [3:0].
REQ-007 neg  output  1  registered sign of the last converted value.
REQ-008 estouro  output  1  registered overflow flag: magnitude exceeds 10^DIGITOS-1.
REQ-009 ocupado  output  1  high while a conversion is in progress.
REQ-010 pronto  output  1  one-cycle pulse marking new results on segmentos/neg/estouro.

Function
REQ-011 The state machine SHALL have two states, OCIOSO and CONVERTE, plus a 6-bit shift counter.
REQ-012 In OCIOSO with iniciar=1 at edge E0: capture magnitude and sign; enter CONVERTE; set ocupado=1 at E0.
REQ-013 Magnitude SHALL be -valor when the sign is negative, else valor; the 32-bit result of negating 32'h80000000 is read as unsigned 2147483648.
REQ-014 CONVERTE SHALL run shift-add-3 (double dabble) on a 10-digit internal BCD register: on each of edges E1..E32, add 3 to every digit >=5, then shift left one bit with the magnitude MSB entering.
REQ-015 At edge E32 the block SHALL, in the same edge: register results; set pronto=1; clear ocupado; return to OCIOSO.
REQ-016 pronto SHALL drop at E33.
REQ-017 The earliest next start SHALL be sampled at E33.
REQ-018 Latency from the iniciar-sampling edge to pronto high SHALL be exactly 32 edges.
REQ-019 Digits 0..DIGITOS-1 SHALL hold the converted value.
REQ-020 Nibbles DIGITOS..7 of segmentos SHALL always be 0.
REQ-021 If any internal digit at index >=DIGITOS is nonzero: estouro=1 and digits 0..DIGITOS-1 = 4'hF each (blank on the downstream decoder).
REQ-022 When no internal digit at index >=DIGITOS is nonzero, estouro SHALL be 0.
REQ-023 neg SHALL reflect the captured sign even when estouro=1.
REQ-024 A zero result SHALL give neg=0.
REQ-025 iniciar while ocupado=1 SHALL be ignored; the value captured at E0 is the value converted.
REQ-026 segmentos, neg and estouro SHALL hold their last values between conversions.
REQ-027 valor SHALL be sampled only at E0; changes afterwards have no effect.

Reset
REQ-028 While reset=1 at an edge: segmentos=0, neg=0, estouro=0, ocupado=0, pronto=0, state=OCIOSO, counter=0.
REQ-029 Reset SHALL take priority over iniciar.
REQ-030 Reset mid-conversion SHALL abort with no pronto pulse.
REQ-031 After reset is released, an iniciar at the next edge SHALL start a normal conversion.

Configuration
REQ-032 CONVERSOR_SINAL_EN defined: valor[31] is the sign and REQ-013 negation applies.
REQ-033 CONVERSOR_SINAL_EN undefined: valor is unsigned; no negation logic exists; neg is constant 0.

Verification
REQ-034 valor=32'd1234, iniciar pulse -> pronto high 32 edges later, segmentos=32'h00001234, neg=0, estouro=0, ocupado low from the same edge.
REQ-035 valor=32'hFFFFFFFB -> with CONVERSOR_SINAL_EN: segmentos=32'h00000005, neg=1. Without CONVERSOR_SINAL_EN: estouro=1, segmentos=32'h00FFFFFF, neg=0.
REQ-036 DIGITOS=6: valor=999999 -> segmentos=32'h00999999, estouro=0. Then valor=1000000 -> segmentos=32'h00FFFFFF, estouro=1.
REQ-037 valor=42 start, then iniciar=1 with valor=77 at edge E5 -> single pronto, segmentos=32'h00000042. Next conversion of 77 is accepted at E33.
REQ-038 Reset asserted at E10 of a conversion -> all outputs 0 and no pronto. A fresh start of valor=8 then yields 32'h00000008 after 32 edges.
REQ-039 With CONVERSOR_SINAL_EN, valor=32'h80000000 -> neg=1, estouro=1, segmentos=32'h00FFFFFF.
